// File: rtl/mux_rr_sched_pkg.sv
// Shared constants and FSM state type for the 31-source round-robin scheduler.
// BURST_W is sized to hold burst counts 0..BURST_MAX-1 (MUX_RR_SCHED_BURST_EN builds).
package mux_sched_pkg;
  localparam int N_SRC     = 31;
  localparam int SEL_W     = 5;
  localparam int DATA_W    = 2;
  localparam int BURST_MAX = 4;
  localparam int BURST_W   = 2;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_SRC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/mux_rr_sched_if.sv
// Request/data/grant bundle between the sources, the scheduler and the downstream sink.
// slave is the scheduler side; master is the requester/sink side.
interface mux_rr_sched_if;
  import mux_sched_pkg::*;

  logic [N_SRC-1:0]        req;
  logic [N_SRC*DATA_W-1:0] din;
  logic                    out_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_id;
  logic [SEL_W-1:0]        sel;
  logic [N_SRC-1:0]        gnt;

  modport slave (
    input  req, din, out_ready,
    output out_valid, out_data, out_id, sel, gnt
  );

  modport master (
    output req, din, out_ready,
    input  out_valid, out_data, out_id, sel, gnt
  );
endinterface

// File: rtl/mux_rr_sched_pick.sv
// Combinational wrap-around priority search: first set req bit above last_grant,
// with index N_SRC-1 wrapping to 0, so the result is always in 0..N_SRC-1.
module mux_rr_pick
  import mux_sched_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last_grant,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W:0]   pos;
  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    cand  = '0;
    // k = N_SRC revisits last_grant itself, which re-grants a lone requester
    for (int k = 1; k <= N_SRC; k++) begin
      pos = {1'b0, last_grant} + (SEL_W+1)'(k);
      if (pos >= (SEL_W+1)'(N_SRC))
        pos = pos - (SEL_W+1)'(N_SRC);
      cand = pos[SEL_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin 31:1 scheduler with a one-item output register and one-hot grant.
// Define MUX_RR_SCHED_BURST_EN to let a still-requesting source keep up to BURST_MAX grants.
//
// state | meaning
// IDLE  | no item held, out_valid=0
// HOLD  | item held in out_data/out_id, out_valid=1
module mux_rr_sched
  import mux_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mux_rr_sched_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_id_q;
  logic [SEL_W-1:0]  last_grant_q;

  logic              xfer;
  logic              keep_same;
  logic              load;
  logic [SEL_W-1:0]  load_idx;
  logic [DATA_W-1:0] load_data;
  logic [SEL_W-1:0]  search_base;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic [N_SRC-1:0]  gnt_w;

  assign xfer = (state_q == ST_HOLD) && bus.out_ready;

  // On a transfer the next search must already start after the item leaving now.
  assign search_base = xfer ? out_id_q : last_grant_q;

  mux_rr_pick u_pick (
    .req        (bus.req),
    .last_grant (search_base),
    .found      (pick_found),
    .idx        (pick_idx)
  );

`ifdef MUX_RR_SCHED_BURST_EN
  logic [BURST_W-1:0] burst_cnt_q;

  assign keep_same = xfer && bus.req[out_id_q] &&
                     (burst_cnt_q < BURST_W'(BURST_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst)
      burst_cnt_q <= '0;
    else if (xfer)
      burst_cnt_q <= keep_same ? burst_cnt_q + 1'b1 : '0;
  end
`else
  assign keep_same = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_idx = pick_idx;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          if (keep_same) begin
            load     = 1'b1;
            load_idx = out_id_q;
          end else if (pick_found) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (load_idx == SEL_W'(i))
        load_data = bus.din[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_data_q   <= '0;
      out_id_q     <= '0;
      last_grant_q <= LAST_IDX;
    end else begin
      state_q <= state_d;
      if (xfer)
        last_grant_q <= out_id_q;
      if (load) begin
        out_id_q   <= load_idx;
        out_data_q <= load_data;
      end
    end
  end

  // Gated by rst so an item dropped by reset never produces a grant pulse.
  always_comb begin
    gnt_w = '0;
    if (xfer && !rst)
      gnt_w[out_id_q] = 1'b1;
  end

  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign bus.sel       = out_id_q;
  assign bus.gnt       = gnt_w;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched; expected grant order follows MUX_RR_SCHED_BURST_EN.
module tb_mux_rr_sched;
  import mux_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic sel_bad = 1'b0;

  always #5 clk = ~clk;

  mux_rr_sched_if bus ();

  mux_rr_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [N_SRC-1:0] oh(input int i);
    return 31'(1) << i;
  endfunction

  always @(negedge clk) begin
    if (bus.sel === 5'd31 || bus.sel !== bus.out_id)
      sel_bad = 1'b1;
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.din = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.din = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_id !== 5'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", bus.out_id); end
    n_tests++; if (bus.out_data !== 2'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
    n_tests++; if (bus.gnt !== 31'd0) begin n_fail++; $display("FAIL reset_gnt: got %h want 0", bus.gnt); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    bus.din = 62'(2'b10) << 10;
    bus.req = oh(5);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    n_tests++; if (bus.out_id !== 5'd5) begin n_fail++; $display("FAIL single_id: got %0d want 5", bus.out_id); end
    n_tests++; if (bus.out_data !== 2'b10) begin n_fail++; $display("FAIL single_data: got %b want 10", bus.out_data); end
    n_tests++; if (bus.gnt !== oh(5)) begin n_fail++; $display("FAIL single_gnt: got %h want %h", bus.gnt, oh(5)); end
    bus.req = '0;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.gnt !== 31'd0) begin n_fail++; $display("FAIL single_gnt_idle: got %h want 0", bus.gnt); end
  endtask

  task automatic test_rotation();
    int exp_q[$];
`ifdef MUX_RR_SCHED_BURST_EN
    exp_q = '{0, 0, 0, 0};
`else
    exp_q = '{0, 3, 30, 0};
`endif
    do_reset();
    bus.req = oh(0) | oh(3) | oh(30);
    bus.out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== 5'(exp_q[i])) begin
        n_fail++; $display("FAIL rotation[%0d]: got valid=%b id=%0d want valid=1 id=%0d", i, bus.out_valid, bus.out_id, exp_q[i]);
      end
      n_tests++; if (bus.gnt !== oh(exp_q[i])) begin
        n_fail++; $display("FAIL rotation_gnt[%0d]: got %h want %h", i, bus.gnt, oh(exp_q[i]));
      end
      if (i == exp_q.size() - 1) bus.req = '0;
    end
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rotation_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_hold();
    do_reset();
    bus.din = {31{2'b01}};
    bus.req = oh(7);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== 5'd7 || bus.out_data !== 2'b01) begin
        n_fail++; $display("FAIL hold[%0d]: got valid=%b id=%0d data=%b want 1/7/01", i, bus.out_valid, bus.out_id, bus.out_data);
      end
      n_tests++; if (bus.gnt !== 31'd0) begin n_fail++; $display("FAIL hold_gnt[%0d]: got %h want 0", i, bus.gnt); end
      bus.din = ~bus.din;
      bus.req = oh(i + 1) | oh(20 + i);
    end
    bus.req = '0;
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.gnt !== oh(7)) begin n_fail++; $display("FAIL hold_release_gnt: got %h want %h", bus.gnt, oh(7)); end
    n_tests++; if (bus.out_data !== 2'b01) begin n_fail++; $display("FAIL hold_release_data: got %b want 01", bus.out_data); end
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.din = 62'(2'b11);
    bus.req = oh(30);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.out_id !== 5'd30 || bus.gnt !== oh(30)) begin
      n_fail++; $display("FAIL wrap_first: got id=%0d gnt=%h want id=30 gnt=%h", bus.out_id, bus.gnt, oh(30));
    end
    bus.req = oh(0);
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== 5'd0 || bus.sel !== 5'd0) begin
      n_fail++; $display("FAIL wrap_zero: got valid=%b id=%0d sel=%0d want 1/0/0", bus.out_valid, bus.out_id, bus.sel);
    end
    n_tests++; if (bus.out_data !== 2'b11) begin n_fail++; $display("FAIL wrap_data: got %b want 11", bus.out_data); end
    bus.req = '0;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    bus.din = (62'(2'b11) << 24) | (62'(2'b01) << 40);
    bus.req = oh(12);
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.out_id !== 5'd12) begin n_fail++; $display("FAIL rsthold_first: got %0d want 12", bus.out_id); end
    bus.req = oh(20);
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.out_id !== 5'd20 || bus.out_data !== 2'b01) begin
      n_fail++; $display("FAIL rsthold_second: got id=%0d data=%b want 20/01", bus.out_id, bus.out_data);
    end
    rst = 1'b1;
    bus.req = oh(0) | oh(15);
    #1;
    n_tests++; if (bus.gnt !== 31'd0) begin n_fail++; $display("FAIL rsthold_gnt: got %h want 0", bus.gnt); end
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0 || bus.out_id !== 5'd0 || bus.out_data !== 2'd0 || bus.sel !== 5'd0 || bus.gnt !== 31'd0) begin
      n_fail++; $display("FAIL rsthold_zero: got valid=%b id=%0d data=%b sel=%0d gnt=%h want all 0", bus.out_valid, bus.out_id, bus.out_data, bus.sel, bus.gnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== 5'd0) begin
      n_fail++; $display("FAIL rsthold_regrant: got valid=%b id=%0d want 1/0", bus.out_valid, bus.out_id);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rsthold_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
`ifdef MUX_RR_SCHED_BURST_EN
    exp_q = '{2, 2, 2, 2, 9, 9, 9, 9, 2};
`else
    exp_q = '{2, 9, 2, 9};
`endif
    do_reset();
    bus.req = oh(2) | oh(9);
    bus.out_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b1 || bus.gnt !== oh(exp_q[i])) begin
        n_fail++; $display("FAIL b2b[%0d]: got valid=%b id=%0d gnt=%h want valid=1 id=%0d", i, bus.out_valid, bus.out_id, bus.gnt, exp_q[i]);
      end
      if (i == exp_q.size() - 1) bus.req = '0;
    end
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_single_repeat();
    do_reset();
    bus.req = oh(4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== 5'd4 || bus.gnt !== oh(4)) begin
        n_fail++; $display("FAIL repeat[%0d]: got valid=%b id=%0d gnt=%h want 1/4", i, bus.out_valid, bus.out_id, bus.gnt);
      end
    end
    bus.req = '0;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL repeat_idle: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_sel_range();
    n_tests++; if (sel_bad !== 1'b0) begin n_fail++; $display("FAIL sel_range: got sel_bad=%b want 0", sel_bad); end
  endtask

  initial begin
    bus.req = '0;
    bus.din = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_hold();
    test_wrap();
    test_reset_in_hold();
    test_back_to_back();
    test_single_repeat();
    test_sel_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_rr_sched.md
MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req  in  31  per-source request; bit i belongs to source i (0..30).
REQ-005 din  in  62  packed source data; source i occupies bits [2i+1:2i].
REQ-006 out_ready  in  1  downstream accepts out_data when high.
REQ-007 out_valid  out  1  out_data/out_id hold a granted item.
REQ-008 out_data  out  2  data of the granted source, captured at grant.
REQ-009 out_id  out  5  index of the granted source (0..30).
REQ-010 sel  out  5  select for the downstream 31:1 2-bit datapath mux; equals out_id.
REQ-011 gnt  out  31  one-hot acknowledge, high for one cycle on the transfer cycle of source out_id.

Function
REQ-012 FSM states SHALL be IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-013 In IDLE with any req bit high, the next edge SHALL select a winner, load out_data/out_id/sel and enter HOLD, giving 1-cycle request-to-valid latency.
REQ-014 The winner SHALL be the first set req bit searching upward from (last_grant+1), with index 30 wrapping to 0.
REQ-015 sel SHALL never take the value 31.
REQ-016 In HOLD with out_ready=0, out_valid, out_data, out_id and sel SHALL stay stable and req changes SHALL be ignored.
REQ-017 A transfer SHALL occur on any cycle where out_valid=1 and out_ready=1.
REQ-018 On a transfer, gnt[out_id] SHALL be high in that same cycle and last_grant SHALL update to out_id.
REQ-019 On a transfer with any req bit high (requester bits included), the same edge SHALL load the next winner and remain in HOLD, giving one item per cycle back-to-back.
REQ-020 On a transfer with no req bit high, the FSM SHALL return to IDLE with out_valid=0.
REQ-021 A requester SHALL hold req until it sees its gnt bit; the block SHALL treat a req bit still high in the gnt cycle as a new request.
REQ-022 With a single active requester, the search SHALL wrap to that same index and re-grant it.
REQ-023 gnt SHALL be all-zero whenever no transfer occurs.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set state=IDLE, out_valid=0, out_data=0, out_id=0, sel=0, gnt=0, last_grant=30 (so the first search starts at 0) and burst_cnt=0.
REQ-025 Reset in HOLD SHALL drop the pending item without a gnt pulse.

Configuration
REQ-026 The burst feature SHALL be controlled by macro MUX_RR_SCHED_BURST_EN.
REQ-027 With MUX_RR_SCHED_BURST_EN defined: on a transfer, if req[out_id]=1 and burst_cnt<BURST_MAX-1, the same source SHALL be re-granted and burst_cnt incremented.
REQ-028 With MUX_RR_SCHED_BURST_EN defined: otherwise arbitration SHALL rotate per REQ-014 and burst_cnt SHALL reset to 0.
REQ-029 Without MUX_RR_SCHED_BURST_EN, arbitration SHALL be pure round-robin and the burst counter SHALL not exist.

Structure
REQ-030 Package mux_sched_pkg SHALL hold the constants N_SRC=31, SEL_W=5, DATA_W=2, BURST_MAX=4 and the FSM state enum.
REQ-031 The combinational wrap-around priority search SHALL be one sub-module, mux_rr_pick (inputs: req, last_grant; outputs: found, idx).

Verification
REQ-032 Reset then req=bit5 with out_ready=1 -> out_valid one cycle later, out_id=5, out_data=din[11:10], gnt[5] pulse, then IDLE.
REQ-033 req=bits{0,3,30} held high with out_ready=1 -> grant order 0,3,30,0 on consecutive cycles with out_valid continuously high.
REQ-034 Grant to 7 with out_ready=0 for 5 cycles while din and req change -> out_data/out_id stable and gnt=0 throughout; first ready cycle gives gnt[7].
REQ-035 last_grant=30 and req=bit0 -> out_id=0 (wrap); sel never equals 31 in any run.
REQ-036 rst asserted in HOLD -> next cycle all outputs zero; after release, req=bit0 is granted first.
REQ-037 MUX_RR_SCHED_BURST_EN defined, req{2,9} held with out_ready=1 -> grants 2,2,2,2,9,9,9,9,2; undefined -> 2,9,2,9.
